// File: rtl/cv32e40p_tmr_fault_manager_if.sv
// Voter-flag / control bundle between the TMR voter, software control and the
// fault manager. The master drives the flags and the control inputs, and the
// slave (the fault manager) returns the remap and status outputs.
interface cv32e40p_tmr_fault_manager_if;
  logic        valid_i;
  logic        err_detected_1_i;
  logic        err_detected_2_i;
  logic        err_detected_3_i;
  logic        err_corrected_i;
  logic        clear_i;
  logic        only_two_o;
  logic [1:0]  sel_a_o;
  logic [1:0]  sel_b_o;
  logic [1:0]  faulty_lane_o;
  logic [1:0]  state_o;
  logic        uncorr_o;
  logic        fatal_o;
  logic [31:0] stat_corr_o;

  modport master (
    output valid_i, err_detected_1_i, err_detected_2_i, err_detected_3_i,
           err_corrected_i, clear_i,
    input  only_two_o, sel_a_o, sel_b_o, faulty_lane_o, state_o, uncorr_o,
           fatal_o, stat_corr_o
  );

  modport slave (
    input  valid_i, err_detected_1_i, err_detected_2_i, err_detected_3_i,
           err_corrected_i, clear_i,
    output only_two_o, sel_a_o, sel_b_o, faulty_lane_o, state_o, uncorr_o,
           fatal_o, stat_corr_o
  );
endinterface

// File: rtl/cv32e40p_tmr_fault_manager.sv
// TMR fault manager: scores each replica lane with a leaky saturating error
// counter, retires a persistently faulty lane (only-two mode and voter input
// remap), and raises a sticky fatal once redundancy can no longer mask a fault.
// Optional corrected-event statistics counter: define CV32E40P_TMR_FAULT_STATS_EN.
module cv32e40p_tmr_fault_manager #(
  parameter int unsigned CNT_W        = 3,
  parameter int unsigned THRESH       = 4,
  parameter int unsigned DECAY_PERIOD = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  cv32e40p_tmr_fault_manager_if.slave    bus
);

  localparam int unsigned      TW         = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
  localparam logic [TW-1:0]    DECAY_LAST = TW'(DECAY_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] THRESH_C   = CNT_W'(THRESH);

  if ((THRESH < 1) || (THRESH > (2**CNT_W) - 1)) begin : g_bad_thresh
    $error("THRESH must lie in 1..2**CNT_W-1");
  end
  if (DECAY_PERIOD < 1) begin : g_bad_decay
    $error("DECAY_PERIOD must be at least 1");
  end

  typedef enum logic [1:0] {
    S_TMR      = 2'd0,
    S_DEGRADED = 2'd1,
    S_FAILED   = 2'd2
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q [3];
  logic [TW-1:0]    timer_q;
  logic             only_two_q;
  logic [1:0]       sel_a_q;
  logic [1:0]       sel_b_q;
  logic [1:0]       faulty_q;
  logic             uncorr_q;
  logic             fatal_q;

  logic [2:0]       flags;
  logic [1:0]       hit_lane;
  logic             single_corr;
  logic [CNT_W-1:0] cnt_inc_d;
  logic             retire;
  logic             decay_now;

  // Classify the flag pattern and precompute the saturated increment of the flagged lane.
  always_comb begin
    flags = {bus.err_detected_3_i, bus.err_detected_2_i, bus.err_detected_1_i};
    case (flags)
      3'b001:  hit_lane = 2'd1;
      3'b010:  hit_lane = 2'd2;
      3'b100:  hit_lane = 2'd3;
      default: hit_lane = 2'd0;
    endcase
    single_corr = (hit_lane != 2'd0) && bus.err_corrected_i;
    cnt_inc_d   = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      if (flags[k]) begin
        cnt_inc_d = (cnt_q[k] == CNT_MAX) ? cnt_q[k] : cnt_q[k] + 1'b1;
      end
    end
    retire    = (cnt_inc_d >= THRESH_C);
    decay_now = (timer_q == DECAY_LAST);
  end

  // Lane-health FSM with registered outputs; clear_i behaves like reset except for statistics.
  always_ff @(posedge clk) begin
    if (rst || bus.clear_i) begin
      state_q    <= S_TMR;
      for (int unsigned k = 0; k < 3; k++) cnt_q[k] <= '0;
      timer_q    <= '0;
      only_two_q <= 1'b0;
      sel_a_q    <= 2'd1;
      sel_b_q    <= 2'd2;
      faulty_q   <= 2'd0;
      uncorr_q   <= 1'b0;
      fatal_q    <= 1'b0;
    end else begin
      uncorr_q <= 1'b0;
      case (state_q)
        S_TMR: begin
          if (bus.valid_i) begin
            if (single_corr) begin
              for (int unsigned k = 0; k < 3; k++) begin
                if (flags[k]) cnt_q[k] <= cnt_inc_d;
              end
              timer_q <= '0;
              if (retire) begin
                state_q    <= S_DEGRADED;
                only_two_q <= 1'b1;
                faulty_q   <= hit_lane;
                case (hit_lane)
                  2'd1:    begin sel_a_q <= 2'd2; sel_b_q <= 2'd3; end
                  2'd2:    begin sel_a_q <= 2'd1; sel_b_q <= 2'd3; end
                  default: begin sel_a_q <= 2'd1; sel_b_q <= 2'd2; end
                endcase
              end
            end else if (|flags) begin
              uncorr_q <= 1'b1;
              fatal_q  <= 1'b1;
              state_q  <= S_FAILED;
            end else if (decay_now) begin
              for (int unsigned k = 0; k < 3; k++) begin
                if (cnt_q[k] != '0) cnt_q[k] <= cnt_q[k] - 1'b1;
              end
              timer_q <= '0;
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          end
        end
        S_DEGRADED: begin
          // Voter input 3 is unused in only-two mode, so its flag carries no information.
          if (bus.valid_i && (bus.err_detected_1_i || bus.err_detected_2_i)) begin
            uncorr_q <= 1'b1;
            fatal_q  <= 1'b1;
            state_q  <= S_FAILED;
          end
        end
        S_FAILED: begin
          fatal_q <= 1'b1;
        end
        default: begin
          fatal_q <= 1'b1;
          state_q <= S_FAILED;
        end
      endcase
    end
  end

`ifdef CV32E40P_TMR_FAULT_STATS_EN
  logic [31:0] stat_q;

  // Saturating corrected-event counter; survives clear_i, only rst zeroes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_q <= '0;
    end else if (!bus.clear_i && bus.valid_i && bus.err_corrected_i &&
                 (state_q == S_TMR) && (stat_q != '1)) begin
      stat_q <= stat_q + 32'd1;
    end
  end

  assign bus.stat_corr_o = stat_q;
`else
  assign bus.stat_corr_o = '0;
`endif

  assign bus.only_two_o    = only_two_q;
  assign bus.sel_a_o       = sel_a_q;
  assign bus.sel_b_o       = sel_b_q;
  assign bus.faulty_lane_o = faulty_q;
  assign bus.state_o       = state_q;
  assign bus.uncorr_o      = uncorr_q;
  assign bus.fatal_o       = fatal_q;

endmodule

// File: tb/tb_cv32e40p_tmr_fault_manager.sv
// Directed bench for the TMR fault manager (CNT_W=3, THRESH=4, DECAY_PERIOD=4).
// Expected outputs are queued when a step is driven and compared one cycle later.
module tb_cv32e40p_tmr_fault_manager;

`ifdef CV32E40P_TMR_FAULT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    logic [1:0]  st;
    logic        ot;
    logic [1:0]  sa;
    logic [1:0]  sb;
    logic [1:0]  fl;
    logic        unc;
    logic        fat;
    logic [31:0] stat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  int          checks = 0;
  int          errors = 0;
  exp_t        sbq[$];
  logic [31:0] stat_exp = '0;
  logic [1:0]  prev_st  = 2'd0;
  string       cur_tag  = "init";

  cv32e40p_tmr_fault_manager_if bus ();

  cv32e40p_tmr_fault_manager #(
    .CNT_W       (3),
    .THRESH      (4),
    .DECAY_PERIOD(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string field, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s: observed %0h expected %0h", cur_tag, field, obs, exp);
    end
  endtask

  // One cycle: drive inputs, queue the expected post-edge outputs, then compare.
  task automatic step(input logic r, input logic v, input logic e1, input logic e2,
                      input logic e3, input logic c, input logic clr,
                      input logic [1:0] st, input logic ot, input logic [1:0] sa,
                      input logic [1:0] sb, input logic [1:0] fl,
                      input logic unc, input logic fat);
    exp_t e;
    @(negedge clk);
    rst                  = r;
    bus.valid_i          = v;
    bus.err_detected_1_i = e1;
    bus.err_detected_2_i = e2;
    bus.err_detected_3_i = e3;
    bus.err_corrected_i  = c;
    bus.clear_i          = clr;
    if (r) stat_exp = '0;
    else if (STATS && (prev_st == 2'd0) && v && c && !clr) stat_exp = stat_exp + 32'd1;
    e.st = st; e.ot = ot; e.sa = sa; e.sb = sb; e.fl = fl;
    e.unc = unc; e.fat = fat; e.stat = stat_exp;
    sbq.push_back(e);
    prev_st = st;
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk("state",    32'(bus.state_o),       32'(e.st));
    chk("only_two", 32'(bus.only_two_o),    32'(e.ot));
    chk("sel_a",    32'(bus.sel_a_o),       32'(e.sa));
    chk("sel_b",    32'(bus.sel_b_o),       32'(e.sb));
    chk("faulty",   32'(bus.faulty_lane_o), 32'(e.fl));
    chk("uncorr",   32'(bus.uncorr_o),      32'(e.unc));
    chk("fatal",    32'(bus.fatal_o),       32'(e.fat));
    chk("stat",     bus.stat_corr_o,        e.stat);
  endtask

  // Step that expects the TMR reset-value outputs.
  task automatic tmr(input logic v, input logic e1, input logic e2, input logic e3,
                     input logic c, input logic clr);
    step(1'b0, v, e1, e2, e3, c, clr, 2'd0, 1'b0, 2'd1, 2'd2, 2'd0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    bus.valid_i = 1'b0; bus.err_detected_1_i = 1'b0; bus.err_detected_2_i = 1'b0;
    bus.err_detected_3_i = 1'b0; bus.err_corrected_i = 1'b0; bus.clear_i = 1'b0;

    cur_tag = "reset";
    step(1, 0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd1, 2'd2, 2'd0, 0, 0);
    step(1, 1, 1, 1, 1, 1, 0, 2'd0, 0, 2'd1, 2'd2, 2'd0, 0, 0);

    // Lane 2 reaches THRESH on the fourth corrected error.
    cur_tag = "retire_lane2";
    tmr(1, 0, 1, 0, 1, 0);
    tmr(0, 1, 1, 1, 0, 0);
    tmr(1, 0, 1, 0, 1, 0);
    tmr(1, 0, 1, 0, 1, 0);
    step(0, 1, 0, 1, 0, 1, 0, 2'd1, 1, 2'd1, 2'd3, 2'd2, 0, 0);

    cur_tag = "degraded_e3_ignored";
    step(0, 1, 0, 0, 1, 1, 0, 2'd1, 1, 2'd1, 2'd3, 2'd2, 0, 0);
    cur_tag = "degraded_e1_fails";
    step(0, 1, 1, 0, 0, 0, 0, 2'd2, 1, 2'd1, 2'd3, 2'd2, 1, 1);
    cur_tag = "failed_hold";
    step(0, 1, 0, 1, 0, 1, 0, 2'd2, 1, 2'd1, 2'd3, 2'd2, 0, 1);

    // Clear from FAILED discards the same-cycle lane-1 error.
    cur_tag = "clear_from_failed";
    tmr(1, 1, 0, 0, 1, 1);

    // Leaky counter: 3 errors, two decays over 8 clean valid cycles, 2 more errors.
    cur_tag = "decay";
    for (int i = 0; i < 3; i++) tmr(1, 1, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      tmr(1, 0, 0, 0, 0, 0);
      if (i % 3 == 1) tmr(0, 1, 0, 1, 1, 0);
    end
    tmr(1, 1, 0, 0, 1, 0);
    tmr(1, 1, 0, 0, 1, 0);
    cur_tag = "decay_retire_lane1";
    step(0, 1, 1, 0, 0, 1, 0, 2'd1, 1, 2'd2, 2'd3, 2'd1, 0, 0);

    // After clear, lane 2 counter restarts from zero.
    cur_tag = "clear_counters";
    tmr(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) tmr(1, 0, 1, 0, 1, 0);

    cur_tag = "tmr_uncorrectable";
    step(0, 1, 1, 1, 1, 0, 0, 2'd2, 0, 2'd1, 2'd2, 2'd0, 1, 1);
    cur_tag = "fatal_sticky";
    for (int i = 0; i < 10; i++)
      step(0, 1, i[0], 0, 1, 1, 0, 2'd2, 0, 2'd1, 2'd2, 2'd0, 0, 1);

    cur_tag = "retire_lane3";
    tmr(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) tmr(1, 0, 0, 1, 1, 0);
    step(0, 1, 0, 0, 1, 1, 0, 2'd1, 1, 2'd1, 2'd2, 2'd3, 0, 0);
    cur_tag = "degraded_e3_only";
    step(0, 1, 0, 0, 1, 0, 0, 2'd1, 1, 2'd1, 2'd2, 2'd3, 0, 0);
    cur_tag = "degraded_two_lane";
    step(0, 1, 1, 1, 0, 0, 0, 2'd2, 1, 2'd1, 2'd2, 2'd3, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 2'd2, 1, 2'd1, 2'd2, 2'd3, 0, 1);

    // Statistics: five corrected events survive clear_i.
    cur_tag = "stats";
    step(1, 0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd1, 2'd2, 2'd0, 0, 0);
    tmr(1, 1, 0, 0, 1, 0);
    tmr(1, 1, 0, 0, 1, 0);
    tmr(0, 1, 0, 0, 1, 0);
    tmr(1, 0, 1, 0, 1, 0);
    tmr(1, 0, 1, 0, 1, 0);
    tmr(1, 0, 0, 1, 1, 0);
    cur_tag = "stats_after_clear";
    tmr(1, 0, 0, 1, 1, 1);
    tmr(0, 0, 0, 0, 0, 0);
    checks++;
    assert (bus.stat_corr_o === (STATS ? 32'd5 : 32'd0)) else begin
      errors++;
      $error("FAIL stats_final: observed %0d expected %0d", bus.stat_corr_o,
             STATS ? 32'd5 : 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
